// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream
//   Parametrised Hamming SEC / SECDED encoder with a valid/ready stream interface and a
//   2-entry output FIFO so that it can run at full throughput under backpressure.
//   Codeword bit [p-1] holds Hamming position p. Parity bits sit at the power-of-two positions,
//   and data bits d1..dN fill the remaining positions in ascending order. When SECDED=1, the top
//   bit makes the whole codeword even weight.
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   ena         block enable; low freezes all state and deasserts both handshakes
//   flush       synchronous clear of the output FIFO (word_count untouched)
//   in_valid    data_in valid
//   in_ready    encoder can accept this cycle (from state only, never from out_ready)
//   data_in     data word, data_in[0] = d1
//   out_valid   code_out valid
//   out_ready   downstream accepts code_out
//   code_out    head-of-FIFO codeword
//   word_count  codewords popped since reset, wraps
module hamming_encoder_stream #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SECDED = 0,
    parameter int unsigned CNT_W  = 16,
    // Smallest r with 2**r >= DATA_W + r + 1, valid over DATA_W = 2..26.
    localparam int unsigned R      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 :
                                     (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned CODE_W = DATA_W + R + SECDED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned N = DATA_W + R;

    // Plain SEC codeword over positions 1..N. Built with shifts and masks so that no bit-select
    // uses a run-time index.
    function automatic logic [N-1:0] sec_encode(input logic [DATA_W-1:0] d);
        logic [N-1:0]      c;
        logic [N-1:0]      mask;
        logic [DATA_W-1:0] dd;
        c  = '0;
        dd = d;
        for (int unsigned p = 1; p <= N; p++) begin
            // Non-powers of two carry data, consumed LSB first.
            if ((p & (p - 1)) != 0) begin
                if (dd[0]) begin
                    c = c | (N'(1) << (p - 1));
                end
                dd = dd >> 1;
            end
        end
        for (int unsigned k = 0; k < R; k++) begin
            mask = '0;
            for (int unsigned p = 1; p <= N; p++) begin
                if (((p >> k) & 32'd1) != 0) begin
                    mask = mask | (N'(1) << (p - 1));
                end
            end
            // A parity position 2**j lies only in mask j, so earlier parity bits never leak in.
            if (^(c & mask)) begin
                c = c | (N'(1) << ((32'd1 << k) - 1));
            end
        end
        return c;
    endfunction

    logic [N-1:0]      sec_word;
    logic [CODE_W-1:0] enc_word;

    assign sec_word = sec_encode(data_in);

    if (SECDED != 0) begin : g_secded
        assign enc_word = {^sec_word, sec_word};
    end else begin : g_sec
        assign enc_word = sec_word;
    end

    // Output FIFO state
    logic [CODE_W-1:0] mem_q [2];
    logic [CODE_W-1:0] mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              push, pop;

    always_comb begin
        // rst is included so that in_ready is low for the whole time reset is asserted.
        in_ready  = ena & ~flush & ~rst & (count_q != 2'd2);
        out_valid = ena & (count_q != 2'd0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready & ~flush;

        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        word_count_d = word_count_q;

        if (ena && flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = enc_word;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d     = ~rd_ptr_q;
                word_count_d = word_count_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            word_count_q <= '0;
        end else begin
            mem_q[0]     <= mem_d[0];
            mem_q[1]     <= mem_d[1];
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            word_count_q <= word_count_d;
        end
    end

    assign code_out   = mem_q[rd_ptr_q];
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb_hamming_encoder_stream
//   Directed bench for hamming_encoder_stream. Four instances run off one clock and reset:
//   a: DATA_W=4 SEC (main stream, backpressure, flush, enable, reset)
//   b: DATA_W=4 SECDED
//   c: DATA_W=8 SEC
//   d: DATA_W=4 SEC with a 4-bit word counter (wrap)
module tb_hamming_encoder_stream;

    logic clk;
    logic rst;

    logic       a_ena, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0] a_data;
    logic [6:0] a_code;
    logic [15:0] a_wc;

    logic       b_in_valid, b_in_ready, b_out_valid;
    logic [3:0] b_data;
    logic [7:0] b_code;
    logic [15:0] b_wc;

    logic        c_in_valid, c_in_ready, c_out_valid;
    logic [7:0]  c_data;
    logic [11:0] c_code;
    logic [15:0] c_wc;

    logic       d_in_valid, d_in_ready, d_out_valid;
    logic [3:0] d_data;
    logic [6:0] d_code;
    logic [3:0] d_wc;

    int n_cmp;
    int n_err;

    // Hand-computed Hamming(7,4) codewords, index = data value (d1 = LSB).
    logic [6:0] tab [16];

    hamming_encoder_stream #(.DATA_W(4), .SECDED(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .ena(a_ena), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .code_out(a_code),
        .word_count(a_wc)
    );

    hamming_encoder_stream #(.DATA_W(4), .SECDED(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .ena(1'b1), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .code_out(b_code),
        .word_count(b_wc)
    );

    hamming_encoder_stream #(.DATA_W(8), .SECDED(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .ena(1'b1), .flush(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .data_in(c_data),
        .out_valid(c_out_valid), .out_ready(1'b1), .code_out(c_code),
        .word_count(c_wc)
    );

    hamming_encoder_stream #(.DATA_W(4), .SECDED(0), .CNT_W(4)) dut_d (
        .clk(clk), .rst(rst), .ena(1'b1), .flush(1'b0),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .data_in(d_data),
        .out_valid(d_out_valid), .out_ready(1'b1), .code_out(d_code),
        .word_count(d_wc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tab = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

        rst = 1'b1;
        a_ena = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_data = '0;
        b_in_valid = 1'b0; b_data = '0;
        c_in_valid = 1'b0; c_data = '0;
        d_in_valid = 1'b0; d_data = '0;

        // Reset state
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_code", 64'(a_code), 64'd0);
        check("rst_wc", 64'(a_wc), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // T1/T2: basic encoding, out_ready high
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_data = 4'b1011;
        b_in_valid = 1'b1; b_data = 4'b0001;
        c_in_valid = 1'b1; c_data = 8'h01;
        tick();
        check("t1_valid_1011", 64'(a_out_valid), 64'd1);
        check("t1_code_1011", 64'(a_code), 64'h55);
        check("t2_secded_0001", 64'(b_code), 64'h87);
        check("t2_w8_01", 64'(c_code), 64'h007);
        c_in_valid = 1'b0;
        a_data = 4'h0;
        b_data = 4'b1011;
        tick();
        check("t1_code_0", 64'(a_code), 64'h00);
        check("t2_secded_1011", 64'(b_code), 64'h55);
        b_in_valid = 1'b0;
        a_data = 4'hF;
        tick();
        check("t1_code_f", 64'(a_code), 64'h7F);
        a_in_valid = 1'b0;
        tick();
        check("t1_drained", 64'(a_out_valid), 64'd0);
        check("t1_wc", 64'(a_wc), 64'd3);

        // T3: backpressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_data = 4'h3;
        #1;
        check("t3_ready_empty", 64'(a_in_ready), 64'd1);
        tick();
        check("t3_code_a", 64'(a_code), 64'h1E);
        a_data = 4'h6;
        tick();
        check("t3_full_not_ready", 64'(a_in_ready), 64'd0);
        tick();
        check("t3_hold_valid", 64'(a_out_valid), 64'd1);
        check("t3_hold_code", 64'(a_code), 64'h1E);
        a_out_ready = 1'b1;
        #1;
        check("t3_full_ready_ignores_out_ready", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        tick();
        check("t3_code_b", 64'(a_code), 64'h33);
        check("t3_valid_b", 64'(a_out_valid), 64'd1);
        tick();
        check("t3_drained", 64'(a_out_valid), 64'd0);
        check("t3_wc", 64'(a_wc), 64'd5);

        // T4: 20 back-to-back words; dut_d streams 17 words alongside to wrap its counter
        a_in_valid = 1'b1; a_data = 4'h0;
        d_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_valid", 64'(a_out_valid), 64'd1);
            check("t4_code", 64'(a_code), 64'(tab[i[3:0]]));
            check("t4_in_ready", 64'(a_in_ready), 64'd1);
            if (i == 15) begin
                check("t6_wc_d_15", 64'(d_wc), 64'd15);
            end
            if (i == 16) begin
                d_in_valid = 1'b0;
            end
            if (i < 19) begin
                a_data = 4'(i + 1);
            end else begin
                a_in_valid = 1'b0;
            end
        end
        check("t6_wc_d_wrap", 64'(d_wc), 64'd1);
        tick();
        check("t4_drained", 64'(a_out_valid), 64'd0);
        check("t4_wc", 64'(a_wc), 64'd25);

        // T5: flush with two words buffered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_data = 4'h5;
        tick();
        a_data = 4'h9;
        tick();
        a_flush = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("t5_flush_in_ready", 64'(a_in_ready), 64'd0);
        check("t5_flush_valid_before", 64'(a_out_valid), 64'd1);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("t5_flush_empty", 64'(a_out_valid), 64'd0);
        check("t5_flush_wc", 64'(a_wc), 64'd25);

        // T5: enable low holds state
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_data = 4'hC;
        tick();
        check("t5_pre_ena_code", 64'(a_code), 64'h61);
        a_ena = 1'b0;
        a_data = 4'hD;
        a_out_ready = 1'b1;
        #1;
        check("t5_ena0_in_ready", 64'(a_in_ready), 64'd0);
        check("t5_ena0_out_valid", 64'(a_out_valid), 64'd0);
        tick();
        tick();
        check("t5_ena0_hold_valid", 64'(a_out_valid), 64'd0);
        check("t5_ena0_hold_wc", 64'(a_wc), 64'd25);
        a_ena = 1'b1;
        a_in_valid = 1'b0;
        #1;
        check("t5_resume_valid", 64'(a_out_valid), 64'd1);
        check("t5_resume_code", 64'(a_code), 64'h61);
        tick();
        check("t5_resume_drained", 64'(a_out_valid), 64'd0);
        check("t5_resume_wc", 64'(a_wc), 64'd26);

        // T6: asynchronous reset mid-stream
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_data = 4'h1;
        tick();
        a_data = 4'h2;
        tick();
        a_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(a_out_valid), 64'd0);
        check("t6_rst_code", 64'(a_code), 64'd0);
        check("t6_rst_wc", 64'(a_wc), 64'd0);
        check("t6_rst_in_ready", 64'(a_in_ready), 64'd0);
        #2;
        rst = 1'b0;
        tick();
        check("t6_fresh_empty", 64'(a_out_valid), 64'd0);
        a_in_valid = 1'b1; a_data = 4'h8;
        a_out_ready = 1'b1;
        tick();
        check("t6_fresh_valid", 64'(a_out_valid), 64'd1);
        check("t6_fresh_code", 64'(a_code), 64'h4B);
        check("t6_fresh_wc0", 64'(a_wc), 64'd0);
        a_in_valid = 1'b0;
        tick();
        check("t6_fresh_drained", 64'(a_out_valid), 64'd0);
        check("t6_fresh_wc1", 64'(a_wc), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
